// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=7 (133o/171o) Viterbi decoder.
//   exp_ab : expected coded pair {A,B} for input u leaving encoder state p (p[0] newest)
//   dec_state_e : decoder control FSM states
package viterbi_pkg;

  localparam int unsigned K          = 7;
  localparam int unsigned NUM_STATES = 1 << (K - 1);
  localparam logic [6:0]  G0         = 7'o133;
  localparam logic [6:0]  G1         = 7'o171;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } dec_state_e;

  // Generator tap bit 6 multiplies u, bit 0 multiplies the oldest bit p[5].
  function automatic logic [1:0] exp_ab(input logic [5:0] state, input logic u);
    logic [6:0] taps;
    taps = {u, state[0], state[1], state[2], state[3], state[4], state[5]};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/viterbi_best_state.sv
// Combinational 64-way argmin over the path metrics.
//   pm   : path metrics, one per trellis state
//   best : index of the smallest metric; the lowest index wins a tie
module viterbi_best_state
  import viterbi_pkg::*;
#(
  parameter int unsigned METRIC_W = 10
) (
  input  logic [METRIC_W-1:0] pm [NUM_STATES],
  output logic [5:0]          best
);

  localparam int unsigned Nodes = 2 * NUM_STATES - 1;

  // Heap-ordered tree: node n has children 2n+1 (lower indices) and 2n+2.
  logic [METRIC_W-1:0] node_pm  [Nodes];
  logic [5:0]          node_idx [Nodes];

  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) begin
      node_pm[NUM_STATES-1+i]  = pm[i];
      node_idx[NUM_STATES-1+i] = 6'(i);
    end
    for (int n = NUM_STATES - 2; n >= 0; n--) begin
      // Strict compare keeps the left (lower-index) child on a tie.
      if (node_pm[2*n+2] < node_pm[2*n+1]) begin
        node_pm[n]  = node_pm[2*n+2];
        node_idx[n] = node_idx[2*n+2];
      end else begin
        node_pm[n]  = node_pm[2*n+1];
        node_idx[n] = node_idx[2*n+1];
      end
    end
  end

  assign best = node_idx[0];

endmodule

// File: rtl/viterbi_decoder_k7.sv
// Streaming soft-decision Viterbi decoder, K=7, register-exchange survivors.
//   Clock, Reset (async, active-high)
//   InValid/InReady handshake for soft pair InA/InB with erasures EraseA/EraseB and InLast
//   OutValid/OutBit/OutLast : decoded bit stream, single-cycle pulses, no backpressure
//   Busy : packet in progress (RUN or FLUSH)
module viterbi_decoder_k7
  import viterbi_pkg::*;
#(
  parameter int unsigned SOFT_W     = 3,
  parameter int unsigned TB_DEPTH   = 48,
  parameter int unsigned METRIC_W   = 10,
  parameter int unsigned TERMINATED = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [SOFT_W-1:0] InA,
  input  logic [SOFT_W-1:0] InB,
  input  logic              EraseA,
  input  logic              EraseB,
  input  logic              InLast,
  output logic              OutValid,
  output logic              OutBit,
  output logic              OutLast,
  output logic              Busy
);

  localparam int unsigned         CntW    = $clog2(TB_DEPTH + 2);
  localparam logic [CntW-1:0]     CntMax  = CntW'(TB_DEPTH + 1);
  localparam logic [CntW-1:0]     DepthC  = CntW'(TB_DEPTH);
  localparam logic [CntW-1:0]     LastPos = CntW'(TB_DEPTH - 1);
  localparam logic [METRIC_W-1:0] PmInit  = METRIC_W'(1) << (METRIC_W - 2);

  dec_state_e          state_q, state_d;
  logic [METRIC_W-1:0] pm_q [NUM_STATES];
  logic [METRIC_W-1:0] pm_d [NUM_STATES];
  logic [METRIC_W-1:0] acs_pm [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_q [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_d [NUM_STATES];
  logic [TB_DEPTH-1:0] acs_surv [NUM_STATES];
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CntW-1:0]     pos_q, pos_d;
  logic                out_valid_q, out_valid_d;
  logic                out_bit_q, out_bit_d;
  logic                out_last_q, out_last_d;
  logic [SOFT_W:0]     bm [4];
  logic [5:0]          best, src;
  logic                accept;

  assign InReady  = (state_q != StFlush);
  assign accept   = InValid & InReady;
  assign Busy     = (state_q != StIdle);
  assign OutValid = out_valid_q;
  assign OutBit   = out_bit_q;
  assign OutLast  = out_last_q;

  viterbi_best_state #(
    .METRIC_W(METRIC_W)
  ) u_best (
    .pm  (pm_q),
    .best(best)
  );

  assign src = (TERMINATED != 0) ? 6'd0 : best;

  // Branch metric for each expected pair, indexed by {expA, expB}.
  always_comb begin : p_bm
    logic [SOFT_W-1:0] ma, mb;
    logic [1:0]        e;
    for (int i = 0; i < 4; i++) begin
      e     = 2'(i);
      ma    = EraseA ? '0 : (e[1] ? ~InA : InA);
      mb    = EraseB ? '0 : (e[0] ? ~InB : InB);
      bm[i] = {1'b0, ma} + {1'b0, mb};
    end
  end

  // Add-compare-select for all states, with MSB normalisation.
  always_comb begin : p_acs
    logic [5:0]          st, p0, p1;
    logic [METRIC_W-1:0] c0, c1;
    logic                all_msb;
    all_msb = 1'b1;
    for (int s = 0; s < NUM_STATES; s++) begin
      st = 6'(s);
      p0 = {1'b0, st[5:1]};
      p1 = {1'b1, st[5:1]};
      c0 = pm_q[p0] + METRIC_W'(bm[exp_ab(p0, st[0])]);
      c1 = pm_q[p1] + METRIC_W'(bm[exp_ab(p1, st[0])]);
      if (c1 < c0) begin
        acs_pm[s]   = c1;
        acs_surv[s] = {surv_q[p1][TB_DEPTH-2:0], st[0]};
      end else begin
        acs_pm[s]   = c0;
        acs_surv[s] = {surv_q[p0][TB_DEPTH-2:0], st[0]};
      end
      all_msb = all_msb & acs_pm[s][METRIC_W-1];
    end
    if (all_msb) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        acs_pm[s][METRIC_W-1] = 1'b0;
      end
    end
  end

  always_comb begin : p_ctrl
    state_d     = state_q;
    pm_d        = pm_q;
    surv_d      = surv_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_bit_d   = out_bit_q;
    unique case (state_q)
      StIdle, StRun: begin
        if (accept) begin
          pm_d   = acs_pm;
          surv_d = acs_surv;
          if (cnt_q < CntMax) cnt_d = cnt_q + CntW'(1);
          // Decision from the pre-update survivors, TB_DEPTH pairs behind the input.
          if (cnt_q >= DepthC) begin
            out_valid_d = 1'b1;
            out_bit_d   = surv_q[best][TB_DEPTH-1];
          end
          if (InLast) begin
            state_d = StFlush;
            pos_d   = (cnt_d >= DepthC) ? LastPos : cnt_d - CntW'(1);
          end else begin
            state_d = StRun;
          end
        end
      end
      StFlush: begin
        out_valid_d = 1'b1;
        out_bit_d   = surv_q[src][pos_q];
        if (pos_q == '0) begin
          out_last_d = 1'b1;
          state_d    = StIdle;
          cnt_d      = '0;
          for (int s = 0; s < NUM_STATES; s++) begin
            pm_d[s]   = (s == 0) ? '0 : PmInit;
            surv_d[s] = '0;
          end
        end else begin
          pos_d = pos_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PmInit;
        surv_q[s] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
      pm_q        <= pm_d;
      surv_q      <= surv_d;
    end
  end

endmodule
